// File: rtl/axi_ram_slave.sv
// AXI4 memory slave: independent read/write engines over one word array.
// INCR/FIXED bursts up to 256 beats, byte strobes, always OKAY.
module axi_ram_slave #(
    parameter int DATA_WIDTH      = 512,
    parameter int ADDR_WIDTH      = 64,
    parameter int ID_WIDTH        = 12,
    parameter int STRB_WIDTH      = DATA_WIDTH / 8,
    parameter int RAM_ADDR_WIDTH  = 16,
    parameter int PIPELINE_OUTPUT = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ID_WIDTH-1:0]   s_axi_awid,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [7:0]            s_axi_awlen,
    input  logic [2:0]            s_axi_awsize,
    input  logic [1:0]            s_axi_awburst,
    input  logic [1:0]            s_axi_awlock,
    input  logic [3:0]            s_axi_awcache,
    input  logic [2:0]            s_axi_awprot,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
    input  logic                  s_axi_wlast,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [ID_WIDTH-1:0]   s_axi_bid,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ID_WIDTH-1:0]   s_axi_arid,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]            s_axi_arlen,
    input  logic [2:0]            s_axi_arsize,
    input  logic [1:0]            s_axi_arburst,
    input  logic [1:0]            s_axi_arlock,
    input  logic [3:0]            s_axi_arcache,
    input  logic [2:0]            s_axi_arprot,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [ID_WIDTH-1:0]   s_axi_rid,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready
);

    localparam int OFF   = $clog2(STRB_WIDTH);
    localparam int IW    = RAM_ADDR_WIDTH - OFF;
    localparam int DEPTH = 1 << IW;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    function automatic logic [ADDR_WIDTH-1:0] next_addr(
        input logic [ADDR_WIDTH-1:0] a,
        input logic [2:0]            size,
        input logic [1:0]            burst
    );
        if (burst == 2'b00) return a;
        return a + (ADDR_WIDTH'(1) << size);
    endfunction

    logic unused_ok;
    assign unused_ok = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot,
                         s_axi_arlock, s_axi_arcache, s_axi_arprot,
                         s_axi_wlast};

    // Holds ready low for the first edge after reset release.
    logic rdy_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdy_q <= 1'b0;
        else        rdy_q <= 1'b1;
    end

    // ---------------- write engine ----------------
    wstate_t               w_state, w_next;
    logic [ID_WIDTH-1:0]   w_id_q;
    logic [ADDR_WIDTH-1:0] w_addr_q;
    logic [7:0]            w_len_q, w_cnt_q;
    logic [2:0]            w_size_q;
    logic [1:0]            w_burst_q;
    logic                  aw_hs, w_hs;
    logic [IW-1:0]         w_idx;

    assign aw_hs = s_axi_awready && s_axi_awvalid;
    assign w_hs  = s_axi_wready && s_axi_wvalid;
    assign w_idx = w_addr_q[RAM_ADDR_WIDTH-1:OFF];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) w_state <= W_IDLE;
        else        w_state <= w_next;
    end

    always_comb begin
        w_next        = w_state;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        unique case (w_state)
            W_IDLE: begin
                s_axi_awready = rdy_q;
                if (rdy_q && s_axi_awvalid) w_next = W_DATA;
            end
            W_DATA: begin
                s_axi_wready = 1'b1;
                if (s_axi_wvalid && w_cnt_q == w_len_q) w_next = W_RESP;
            end
            W_RESP: begin
                s_axi_bvalid = 1'b1;
                if (s_axi_bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_id_q    <= '0;
            w_addr_q  <= '0;
            w_len_q   <= '0;
            w_cnt_q   <= '0;
            w_size_q  <= '0;
            w_burst_q <= '0;
        end else if (aw_hs) begin
            w_id_q    <= s_axi_awid;
            w_addr_q  <= s_axi_awaddr;
            w_len_q   <= s_axi_awlen;
            w_cnt_q   <= '0;
            w_size_q  <= s_axi_awsize;
            w_burst_q <= s_axi_awburst;
        end else if (w_hs) begin
            w_cnt_q  <= w_cnt_q + 8'd1;
            w_addr_q <= next_addr(w_addr_q, w_size_q, w_burst_q);
        end
    end

    // Storage is intentionally not reset so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (w_hs) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (s_axi_wstrb[b])
                    mem[w_idx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
            end
        end
    end

    assign s_axi_bid   = w_id_q;
    assign s_axi_bresp = 2'b00;

    // ---------------- read engine ----------------
    rstate_t               r_state, r_next;
    logic [ID_WIDTH-1:0]   r_id_q;
    logic [ADDR_WIDTH-1:0] r_addr_q;
    logic [7:0]            r_len_q, r_cnt_q;
    logic [2:0]            r_size_q;
    logic [1:0]            r_burst_q;
    logic                  s0_valid, s0_last, s0_ready;
    logic [DATA_WIDTH-1:0] s0_data;
    logic                  ar_hs, s0_hs;

    assign ar_hs = s_axi_arready && s_axi_arvalid;
    assign s0_hs = s0_valid && s0_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= R_IDLE;
        else        r_state <= r_next;
    end

    always_comb begin
        r_next        = r_state;
        s_axi_arready = 1'b0;
        unique case (r_state)
            R_IDLE: begin
                s_axi_arready = rdy_q;
                if (rdy_q && s_axi_arvalid) r_next = R_DATA;
            end
            R_DATA: begin
                if (s0_hs && s0_last) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    // r_addr_q always points at the beat after the one held in s0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_id_q    <= '0;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
            r_size_q  <= '0;
            r_burst_q <= '0;
            s0_valid  <= 1'b0;
            s0_last   <= 1'b0;
            s0_data   <= '0;
        end else if (ar_hs) begin
            r_id_q    <= s_axi_arid;
            r_len_q   <= s_axi_arlen;
            r_cnt_q   <= '0;
            r_size_q  <= s_axi_arsize;
            r_burst_q <= s_axi_arburst;
            r_addr_q  <= next_addr(s_axi_araddr, s_axi_arsize,
                                   s_axi_arburst);
            s0_data   <= mem[s_axi_araddr[RAM_ADDR_WIDTH-1:OFF]];
            s0_valid  <= 1'b1;
            s0_last   <= (s_axi_arlen == 8'd0);
        end else if (s0_hs) begin
            if (s0_last) begin
                s0_valid <= 1'b0;
            end else begin
                s0_data  <= mem[r_addr_q[RAM_ADDR_WIDTH-1:OFF]];
                r_addr_q <= next_addr(r_addr_q, r_size_q, r_burst_q);
                r_cnt_q  <= r_cnt_q + 8'd1;
                s0_last  <= (r_cnt_q + 8'd1 == r_len_q);
            end
        end
    end

    assign s_axi_rresp = 2'b00;

    generate
        if (PIPELINE_OUTPUT != 0) begin : g_pipe
            logic                  p_valid, p_last;
            logic [DATA_WIDTH-1:0] p_data;
            logic [ID_WIDTH-1:0]   p_id;

            assign s0_ready = !p_valid || s_axi_rready;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    p_valid <= 1'b0;
                    p_last  <= 1'b0;
                    p_data  <= '0;
                    p_id    <= '0;
                end else if (s0_ready) begin
                    p_valid <= s0_valid;
                    p_last  <= s0_last;
                    p_data  <= s0_data;
                    p_id    <= r_id_q;
                end
            end

            assign s_axi_rvalid = p_valid;
            assign s_axi_rlast  = p_last;
            assign s_axi_rdata  = p_data;
            assign s_axi_rid    = p_id;
        end else begin : g_direct
            assign s0_ready     = s_axi_rready;
            assign s_axi_rvalid = s0_valid;
            assign s_axi_rlast  = s0_last;
            assign s_axi_rdata  = s0_data;
            assign s_axi_rid    = r_id_q;
        end
    endgenerate

endmodule

// File: tb/tb_axi_ram_slave.sv
// Directed self-checking bench for axi_ram_slave.
// Hand-computed expectations for reset, bursts, strobes and persistence.
module tb_axi_ram_slave;

    localparam int DW = 512;
    localparam int AW = 64;
    localparam int IW = 12;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [IW-1:0] awid;
    logic [AW-1:0] awaddr;
    logic [7:0]    awlen;
    logic [2:0]    awsize;
    logic [1:0]    awburst;
    logic          awvalid, awready;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic          wlast, wvalid, wready;
    logic [IW-1:0] bid;
    logic [1:0]    bresp;
    logic          bvalid, bready;
    logic [IW-1:0] arid;
    logic [AW-1:0] araddr;
    logic [7:0]    arlen;
    logic [2:0]    arsize;
    logic [1:0]    arburst;
    logic          arvalid, arready;
    logic [IW-1:0] rid;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rlast, rvalid, rready;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    axi_ram_slave dut (
        .clk(clk), .rst_n(rst_n),
        .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen),
        .s_axi_awsize(awsize), .s_axi_awburst(awburst),
        .s_axi_awlock(2'b00), .s_axi_awcache(4'h0), .s_axi_awprot(3'h0),
        .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid),
        .s_axi_bready(bready),
        .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
        .s_axi_arsize(arsize), .s_axi_arburst(arburst),
        .s_axi_arlock(2'b00), .s_axi_arcache(4'h0), .s_axi_arprot(3'h0),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp),
        .s_axi_rlast(rlast), .s_axi_rvalid(rvalid), .s_axi_rready(rready)
    );

    task automatic check(input string tag, input logic [DW-1:0] got,
                         input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic aw_send(input logic [IW-1:0] id, input logic [AW-1:0] a,
                           input logic [7:0] len, input logic [1:0] burst);
        bit ok = 0;
        awid = id; awaddr = a; awlen = len; awsize = 3'd6;
        awburst = burst; awvalid = 1'b1;
        repeat (50) if (!ok) begin @(negedge clk); ok = awready; end
        if (!ok) check("aw_timeout", 0, 1);
        else @(posedge clk);
        #1 awvalid = 1'b0;
    endtask

    task automatic w_send(input logic [DW-1:0] d, input logic [SW-1:0] s);
        bit ok = 0;
        wdata = d; wstrb = s; wvalid = 1'b1;
        repeat (50) if (!ok) begin @(negedge clk); ok = wready; end
        if (!ok) check("w_timeout", 0, 1);
        else @(posedge clk);
        #1 wvalid = 1'b0;
    endtask

    task automatic b_recv(input logic [IW-1:0] exp_id);
        bit ok = 0;
        bready = 1'b1;
        repeat (50) if (!ok) begin @(negedge clk); ok = bvalid; end
        if (!ok) check("b_timeout", 0, 1);
        else begin
            check("bid", bid, exp_id);
            check("bresp", bresp, 2'b00);
            @(posedge clk);
        end
        #1 bready = 1'b0;
    endtask

    task automatic ar_send(input logic [IW-1:0] id, input logic [AW-1:0] a,
                           input logic [7:0] len, input logic [1:0] burst);
        bit ok = 0;
        arid = id; araddr = a; arlen = len; arsize = 3'd6;
        arburst = burst; arvalid = 1'b1;
        repeat (50) if (!ok) begin @(negedge clk); ok = arready; end
        if (!ok) check("ar_timeout", 0, 1);
        else @(posedge clk);
        #1 arvalid = 1'b0;
    endtask

    // Single-beat read; rvalid must already be up one cycle after AR.
    task automatic r_one(input string tag, input logic [IW-1:0] id,
                         input logic [DW-1:0] exp);
        @(negedge clk);
        check({tag, "_rvalid"}, rvalid, 1'b1);
        check({tag, "_rdata"}, rdata, exp);
        check({tag, "_rlast"}, rlast, 1'b1);
        check({tag, "_rid"}, rid, id);
        check({tag, "_rresp"}, rresp, 2'b00);
        rready = 1'b1;
        @(posedge clk);
        #1 rready = 1'b0;
    endtask

    task automatic wr_one(input logic [IW-1:0] id, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [SW-1:0] s);
        aw_send(id, a, 8'd0, 2'b01);
        w_send(d, s);
        b_recv(id);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] pat, prev, ones;
        logic [SW-1:0] full;
        int beat, cyc;
        bit stalled;

        full = '1;
        ones = '1;
        rst_n = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0;
        awvalid = 0; wdata = '0; wstrb = '0; wlast = 0; wvalid = 0;
        bready = 0; arid = '0; araddr = '0; arlen = '0; arsize = '0;
        arburst = '0; arvalid = 0; rready = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_awready", awready, 0);
        check("rst_arready", arready, 0);
        check("rst_wready", wready, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_rvalid", rvalid, 0);
        rst_n = 1'b1;
        #1 check("rel_awready_pre", awready, 0);
        @(negedge clk);
        check("rel_awready", awready, 1);
        check("rel_arready", arready, 1);
        @(posedge clk); #1;

        pat = {16{32'hA5C3_0F5A}};
        wr_one(12'h123, 64'h40, pat, full);
        ar_send(12'h456, 64'h40, 8'd0, 2'b01);
        r_one("single", 12'h456, pat);

        aw_send(12'h0AB, 64'h0, 8'd31, 2'b01);
        for (int i = 0; i < 32; i++) w_send(DW'(i), full);
        b_recv(12'h0AB);

        ar_send(12'h007, 64'h0, 8'd31, 2'b01);
        beat = 0; cyc = 0; stalled = 0; prev = '0;
        while (beat < 32 && cyc < 200) begin
            rready = cyc[0];
            @(negedge clk);
            if (rvalid) begin
                if (stalled) check("burst_stable", rdata, prev);
                if (rready) begin
                    check("burst_data", rdata, DW'(beat));
                    check("burst_last", rlast, beat == 31);
                    check("burst_rid", rid, 12'h007);
                    beat++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    prev = rdata;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        rready = 1'b0;
        if (beat < 32) check("burst_timeout", beat, 32);
        @(negedge clk);
        check("burst_arready_back", arready, 1);
        @(posedge clk); #1;

        wr_one(12'h011, 64'h0, ones, full);
        wr_one(12'h012, 64'h0, '0, 64'h0000_0000_0000_000F);
        ar_send(12'h013, 64'h0, 8'd0, 2'b01);
        r_one("strobe", 12'h013, ~(DW'(32'hFFFF_FFFF)));

        aw_send(12'h021, 64'h80, 8'd3, 2'b00);
        for (int i = 1; i <= 4; i++) w_send(DW'(i), full);
        b_recv(12'h021);
        ar_send(12'h022, 64'h80, 8'd0, 2'b01);
        r_one("fixed", 12'h022, DW'(4));
        ar_send(12'h023, 64'hC0, 8'd0, 2'b01);
        r_one("fixed_neigh", 12'h023, DW'(3));

        pat = {8{64'hDEAD_BEEF_0123_4567}};
        wr_one(12'h031, 64'h140, pat, full);
        ar_send(12'h032, 64'h0, 8'd7, 2'b01);
        @(negedge clk);
        check("pre_rst_rvalid", rvalid, 1);
        #1 rst_n = 1'b0;
        #1 check("async_rvalid", rvalid, 0);
        check("async_arready", arready, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        ar_send(12'h033, 64'h140, 8'd0, 2'b01);
        r_one("persist", 12'h033, pat);
        ar_send(12'h034, 64'h1_0000_0140, 8'd0, 2'b01);
        r_one("alias", 12'h034, pat);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
